uart_tx_arb: RTL and testbench

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_tx_arb_rr_pick.sv | 30 +++
 rtl/uart_tx_arb.sv | 125 ++++++++++++
 tb/tb_uart_tx_arb.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width, line configuration and the frame arbiter state type.
package uart_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef struct packed {
    logic [15:0] baud_div;
    logic        parity_en;
    logic        parity_odd;
    logic        stop2;
  } conf_t;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    START,
    WAIT_DONE
  } arb_st_t;

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Round-robin picker: one-hot grant to the first active request after ptr, wrapping modulo NREQ.
module rr_pick #(
  parameter int unsigned NREQ = 2
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         gnt,
  output logic                    valid
);

  localparam int unsigned PW = $clog2(NREQ);

  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      idx = PW'((32'(ptr) + i) % NREQ);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    valid = found;
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter that fills a UART frame buffer from one of NREQ byte streams per frame.
// Optional START timeout is compiled in with `define UART_ARB_TMO_EN.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned SZ   = 4,
  parameter int unsigned TMO  = 255
) (
  input  logic                          osc,
  input  logic                          rst,
  input  logic [NREQ-1:0]               req,
  input  logic [NREQ-1:0][BYTE_W-1:0]   wdata,
  input  logic [NREQ-1:0]               wvalid,
  input  logic [NREQ-1:0]               wlast,
  output logic                          wready,
  output logic [NREQ-1:0]               gnt,
  output logic [NREQ-1:0]               done,
  output logic                          err,
  output logic [SZ-1:0][BYTE_W-1:0]     tx_data,
  output logic                          en_tx,
  input  logic                          tx_busy
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned CW = $clog2(SZ + 1);

  arb_st_t         state, next_state;
  logic [IW-1:0]   ptr, gnt_id, pick_id;
  logic [NREQ-1:0] gnt_sel, pick_gnt;
  logic            pick_valid;
  logic [CW-1:0]   cnt;
  logic            accept, frame_end, served, timed_out;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .gnt   (pick_gnt),
    .valid (pick_valid)
  );

  always_comb begin
    pick_id = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick_gnt[i]) pick_id = IW'(i);
    end
  end

  assign accept    = (state == FILL) && wvalid[gnt_id];
  assign frame_end = accept && (wlast[gnt_id] || (cnt == CW'(SZ - 1)));
  assign served    = (state == WAIT_DONE) && !tx_busy;

`ifdef UART_ARB_TMO_EN
  localparam int unsigned TW = $clog2(TMO + 1);
  logic [TW-1:0] tmo_cnt;

  assign timed_out = (state == START) && !tx_busy && (tmo_cnt == TW'(TMO - 1));

  always_ff @(posedge osc or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
      err     <= 1'b0;
    end else begin
      err     <= timed_out;
      tmo_cnt <= ((state == START) && !tx_busy) ? tmo_cnt + TW'(1) : '0;
    end
  end
`else
  assign timed_out = 1'b0;
  assign err       = 1'b0;
`endif

  always_ff @(posedge osc or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:      if (pick_valid) next_state = FILL;
      FILL:      if (frame_end)  next_state = START;
      START: begin
        if (tx_busy)        next_state = WAIT_DONE;
        else if (timed_out) next_state = IDLE;
      end
      WAIT_DONE: if (!tx_busy)   next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  always_comb begin
    wready = (state == FILL);
    en_tx  = (state == START);
    gnt    = (state != IDLE) ? gnt_sel : '0;
  end

  // done is registered so it lands in the first IDLE cycle; the next grant follows one cycle later.
  always_ff @(posedge osc or posedge rst) begin
    if (rst) begin
      ptr     <= IW'(NREQ - 1);
      gnt_id  <= '0;
      gnt_sel <= '0;
      cnt     <= '0;
      tx_data <= '0;
      done    <= '0;
    end else begin
      done <= served ? gnt_sel : '0;
      if ((state == IDLE) && pick_valid) begin
        gnt_id  <= pick_id;
        gnt_sel <= pick_gnt;
        tx_data <= '0;
        cnt     <= '0;
      end
      if (accept) begin
        for (int unsigned i = 0; i < SZ; i++) begin
          if (cnt == CW'(i)) tx_data[i] <= wdata[gnt_id];
        end
        cnt <= cnt + CW'(1);
      end
      if (served || timed_out) ptr <= gnt_id;
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed self-checking bench for uart_tx_arb (NREQ=2, SZ=4); UART_ARB_TMO_EN selects the timeout test.
module tb_uart_tx_arb;

  localparam int unsigned NREQ = 2;
  localparam int unsigned SZ   = 4;
`ifdef UART_ARB_TMO_EN
  localparam int unsigned TMO_P = 16;
`else
  localparam int unsigned TMO_P = 255;
`endif

  logic                     osc = 1'b0;
  logic                     rst;
  logic [NREQ-1:0]          req;
  logic [NREQ-1:0][7:0]     wdata;
  logic [NREQ-1:0]          wvalid, wlast;
  logic                     wready;
  logic [NREQ-1:0]          gnt, done;
  logic                     err;
  logic [SZ-1:0][7:0]       tx_data;
  logic                     en_tx;
  logic                     tx_busy;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_arb #(.NREQ(NREQ), .SZ(SZ), .TMO(TMO_P)) dut (
    .osc     (osc),
    .rst     (rst),
    .req     (req),
    .wdata   (wdata),
    .wvalid  (wvalid),
    .wlast   (wlast),
    .wready  (wready),
    .gnt     (gnt),
    .done    (done),
    .err     (err),
    .tx_data (tx_data),
    .en_tx   (en_tx),
    .tx_busy (tx_busy)
  );

  always #5 osc = ~osc;

  task automatic tick();
    @(posedge osc);
    #1;
  endtask

  task automatic wait_gnt(output int id, output bit ok);
    ok = 1'b0;
    id = 0;
    for (int i = 0; i < 40; i++) begin
      if (gnt != '0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    for (int j = 0; j < NREQ; j++) if (gnt[j]) id = j;
  endtask

  task automatic send_byte(input int id, input logic [7:0] b, input logic last);
    wvalid[id] = 1'b1;
    wdata[id]  = b;
    wlast[id]  = last;
    tick();
    wvalid[id] = 1'b0;
    wlast[id]  = 1'b0;
  endtask

  task automatic uart_serve(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (en_tx) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (ok) begin
      tx_busy = 1'b1;
      tick();
      tick();
      tick();
      tx_busy = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; wdata = '0; wvalid = '0; wlast = '0; tx_busy = 1'b0;
    tick();
    tick();
    n_checks++; if (gnt !== '0)     begin n_fail++; $display("FAIL reset_gnt: got %b expected 00", gnt); end
    n_checks++; if (done !== '0)    begin n_fail++; $display("FAIL reset_done: got %b expected 00", done); end
    n_checks++; if (err !== 1'b0)   begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
    n_checks++; if (en_tx !== 1'b0) begin n_fail++; $display("FAIL reset_en_tx: got %b expected 0", en_tx); end
    n_checks++; if (wready !== 1'b0) begin n_fail++; $display("FAIL reset_wready: got %b expected 0", wready); end
    n_checks++; if (tx_data !== 32'h0) begin n_fail++; $display("FAIL reset_tx_data: got %h expected 00000000", tx_data); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_four_bytes();
    req = 2'b01;
    wvalid[1] = 1'b1;
    wdata[1]  = 8'hFF;
    tick();
    n_checks++; if (gnt !== 2'b01)   begin n_fail++; $display("FAIL fb_grant: got %b expected 01", gnt); end
    n_checks++; if (wready !== 1'b1) begin n_fail++; $display("FAIL fb_wready_fill: got %b expected 1", wready); end
    send_byte(0, 8'h31, 1'b0);
    send_byte(0, 8'h32, 1'b0);
    send_byte(0, 8'h33, 1'b0);
    send_byte(0, 8'h34, 1'b1);
    req = '0;
    wvalid[1] = 1'b0;
    n_checks++; if (tx_data !== {8'h34, 8'h33, 8'h32, 8'h31}) begin n_fail++; $display("FAIL fb_tx_data: got %h expected 34333231", tx_data); end
    n_checks++; if (en_tx !== 1'b1)  begin n_fail++; $display("FAIL fb_en_tx_start: got %b expected 1", en_tx); end
    n_checks++; if (wready !== 1'b0) begin n_fail++; $display("FAIL fb_wready_start: got %b expected 0", wready); end
    tick(); tick(); tick();
    n_checks++; if (en_tx !== 1'b1)  begin n_fail++; $display("FAIL fb_en_tx_held: got %b expected 1", en_tx); end
    n_checks++; if (gnt !== 2'b01)   begin n_fail++; $display("FAIL fb_gnt_held: got %b expected 01", gnt); end
    tx_busy = 1'b1;
    tick();
    n_checks++; if (en_tx !== 1'b0)  begin n_fail++; $display("FAIL fb_en_tx_drop: got %b expected 0", en_tx); end
    tick(); tick();
    n_checks++; if (done !== '0)     begin n_fail++; $display("FAIL fb_done_early: got %b expected 00", done); end
    n_checks++; if (tx_data !== {8'h34, 8'h33, 8'h32, 8'h31}) begin n_fail++; $display("FAIL fb_tx_stable: got %h expected 34333231", tx_data); end
    tx_busy = 1'b0;
    tick();
    n_checks++; if (done !== 2'b01)  begin n_fail++; $display("FAIL fb_done: got %b expected 01", done); end
    n_checks++; if (gnt !== '0)      begin n_fail++; $display("FAIL fb_gnt_clear: got %b expected 00", gnt); end
    tick();
    n_checks++; if (done !== '0)     begin n_fail++; $display("FAIL fb_done_pulse: got %b expected 00", done); end
    n_checks++; if (err !== 1'b0)    begin n_fail++; $display("FAIL fb_err: got %b expected 0", err); end
  endtask

  task automatic test_single_byte();
    bit ok;
    req = 2'b10;
    tick();
    n_checks++; if (gnt !== 2'b10) begin n_fail++; $display("FAIL sb_grant: got %b expected 10", gnt); end
    send_byte(1, 8'hA5, 1'b1);
    req = '0;
    n_checks++; if (tx_data !== {8'h00, 8'h00, 8'h00, 8'hA5}) begin n_fail++; $display("FAIL sb_tx_data: got %h expected 000000a5", tx_data); end
    uart_serve(ok);
    n_checks++; if (ok !== 1'b1)   begin n_fail++; $display("FAIL sb_en_tx_timeout: got %b expected 1", ok); end
    n_checks++; if (done !== 2'b10) begin n_fail++; $display("FAIL sb_done: got %b expected 10", done); end
    tick(); tick();
    n_checks++; if ({gnt, en_tx} !== 3'b000) begin n_fail++; $display("FAIL sb_one_frame: got %b expected 000", {gnt, en_tx}); end
  endtask

  task automatic test_round_robin();
    int ids [4];
    int id;
    bit ok, ok2;
    req = 2'b11;
    for (int f = 0; f < 4; f++) begin
      wait_gnt(id, ok);
      n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rr_grant_timeout[%0d]: got %b expected 1", f, ok); end
      ids[f] = ok ? id : 9;
      send_byte(id, 8'(8'h50 + f), 1'b1);
      uart_serve(ok2);
      n_checks++; if (done !== 2'(1 << id)) begin n_fail++; $display("FAIL rr_done[%0d]: got %b expected %b", f, done, 2'(1 << id)); end
      n_checks++; if (gnt !== '0) begin n_fail++; $display("FAIL rr_gap[%0d]: got %b expected 00", f, gnt); end
    end
    req = '0;
    n_checks++;
    if (ids[0] !== 0 || ids[1] !== 1 || ids[2] !== 0 || ids[3] !== 1) begin
      n_fail++; $display("FAIL rr_order: got %0d%0d%0d%0d expected 0101", ids[0], ids[1], ids[2], ids[3]);
    end
    tick();
  endtask

  task automatic test_overflow();
    int id, k, guard;
    bit ok;
    req = 2'b01;
    wait_gnt(id, ok);
    n_checks++; if (id !== 0) begin n_fail++; $display("FAIL ov_grant1: got %0d expected 0", id); end
    k = 0; guard = 0;
    while (k < 6 && wready && guard < 20) begin
      wvalid[0] = 1'b1; wdata[0] = 8'(8'h41 + k); wlast[0] = 1'b0;
      tick();
      k++; guard++;
    end
    wdata[0] = 8'(8'h41 + k);
    n_checks++; if (k !== 4) begin n_fail++; $display("FAIL ov_bytes1: got %0d expected 4", k); end
    n_checks++; if (tx_data !== {8'h44, 8'h43, 8'h42, 8'h41}) begin n_fail++; $display("FAIL ov_tx_data1: got %h expected 44434241", tx_data); end
    uart_serve(ok);
    n_checks++; if (done !== 2'b01) begin n_fail++; $display("FAIL ov_done1: got %b expected 01", done); end
    wait_gnt(id, ok);
    n_checks++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL ov_grant2: got %b expected 01", gnt); end
    guard = 0;
    while (k < 6 && wready && guard < 20) begin
      wvalid[0] = 1'b1; wdata[0] = 8'(8'h41 + k);
      tick();
      k++; guard++;
    end
    wvalid[0] = 1'b0;
    n_checks++; if (tx_data !== {8'h00, 8'h00, 8'h46, 8'h45}) begin n_fail++; $display("FAIL ov_tx_data2: got %h expected 00004645", tx_data); end
    n_checks++; if (wready !== 1'b1) begin n_fail++; $display("FAIL ov_still_fill: got %b expected 1", wready); end
    req = '0;
    rst = 1'b1; tick(); rst = 1'b0; tick();
  endtask

  task automatic test_reset_wait_done();
    int id;
    bit ok;
    req = 2'b10;
    wait_gnt(id, ok);
    send_byte(1, 8'h5A, 1'b1);
    req = '0;
    tx_busy = 1'b1;
    tick();
    n_checks++; if ({gnt, en_tx} !== 3'b100) begin n_fail++; $display("FAIL rw_in_wait: got %b expected 100", {gnt, en_tx}); end
    rst = 1'b1;
    #1;
    n_checks++; if ({gnt, done, err, en_tx, wready} !== 7'b0) begin n_fail++; $display("FAIL rw_async_outputs: got %b expected 0000000", {gnt, done, err, en_tx, wready}); end
    n_checks++; if (tx_data !== 32'h0) begin n_fail++; $display("FAIL rw_async_tx_data: got %h expected 00000000", tx_data); end
    tx_busy = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    n_checks++; if (done !== '0) begin n_fail++; $display("FAIL rw_no_done: got %b expected 00", done); end
    req = 2'b11;
    wait_gnt(id, ok);
    n_checks++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL rw_first_after_reset: got %b expected 01", gnt); end
    req = '0;
    rst = 1'b1; tick(); rst = 1'b0; tick();
  endtask

`ifdef UART_ARB_TMO_EN
  task automatic test_timeout();
    int id, n;
    bit ok;
    req = 2'b01;
    wait_gnt(id, ok);
    send_byte(0, 8'h77, 1'b1);
    req = '0;
    n_checks++; if (en_tx !== 1'b1) begin n_fail++; $display("FAIL to_en_tx: got %b expected 1", en_tx); end
    n = 0;
    while (!err && n < 100) begin
      tick();
      n++;
    end
    n_checks++; if (n !== 16) begin n_fail++; $display("FAIL to_err_delay: got %0d expected 16", n); end
    n_checks++; if ({gnt, done, en_tx} !== 5'b0) begin n_fail++; $display("FAIL to_abort: got %b expected 00000", {gnt, done, en_tx}); end
    tick();
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL to_err_pulse: got %b expected 0", err); end
  endtask
`else
  task automatic test_no_timeout();
    int id, err_seen;
    bit ok;
    req = 2'b01;
    wait_gnt(id, ok);
    send_byte(0, 8'h77, 1'b1);
    req = '0;
    err_seen = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (err) err_seen++;
    end
    n_checks++; if (err_seen !== 0) begin n_fail++; $display("FAIL nt_err_seen: got %0d expected 0", err_seen); end
    n_checks++; if (en_tx !== 1'b1) begin n_fail++; $display("FAIL nt_en_tx_waits: got %b expected 1", en_tx); end
    rst = 1'b1; tick(); rst = 1'b0; tick();
  endtask
`endif

  initial begin
    test_reset();
    test_four_bytes();
    test_single_byte();
    test_round_robin();
    test_overflow();
    test_reset_wait_done();
`ifdef UART_ARB_TMO_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got time %0t expected test end", $time);
    $fatal(1);
  end

endmodule
